// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register for the RV32 pipeline.
//   Captures the ALU result and pass-through fields from EX. It holds when en
//   is low and clears to a bubble on flush. It also drives a registered
//   forwarding source and a load-pending flag for the hazard unit.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   en, flush         capture enable (0 = stall), synchronous bubble insert
//   *_in              EX-stage fields (valid, ALU result, store data, PC+4,
//                     rd, Wbsel, MemRw, RegWen, Rsel, Wsel)
//   *_out             registered copies; MemRw_out/RegWen_out gated by valid
//   fwd_valid/regd/data  forwardable result held in this stage
//   load_pending      valid load to a nonzero rd is in this stage
module ex_mem_stage #(
  parameter int unsigned datawidth = 32,
  parameter int unsigned regindex  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 flush,
  input  logic                 valid_in,
  input  logic [datawidth-1:0] aluresult_in,
  input  logic [datawidth-1:0] storedata_in,
  input  logic [datawidth-1:0] pc4_in,
  input  logic [regindex-1:0]  regd_in,
  input  logic [1:0]           Wbsel_in,
  input  logic                 MemRw_in,
  input  logic                 RegWen_in,
  input  logic [2:0]           Rsel_in,
  input  logic [1:0]           Wsel_in,
  output logic                 valid_out,
  output logic [datawidth-1:0] aluresult_out,
  output logic [datawidth-1:0] storedata_out,
  output logic [datawidth-1:0] pc4_out,
  output logic [regindex-1:0]  regd_out,
  output logic [1:0]           Wbsel_out,
  output logic                 MemRw_out,
  output logic                 RegWen_out,
  output logic [2:0]           Rsel_out,
  output logic [1:0]           Wsel_out,
  output logic                 fwd_valid,
  output logic [regindex-1:0]  fwd_regd,
  output logic [datawidth-1:0] fwd_data,
  output logic                 load_pending
);

  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  logic                 valid_q,     valid_d;
  logic [datawidth-1:0] aluresult_q, aluresult_d;
  logic [datawidth-1:0] storedata_q, storedata_d;
  logic [datawidth-1:0] pc4_q,       pc4_d;
  logic [regindex-1:0]  regd_q,      regd_d;
  logic [1:0]           Wbsel_q,     Wbsel_d;
  logic                 MemRw_q,     MemRw_d;
  logic                 RegWen_q,    RegWen_d;
  logic [2:0]           Rsel_q,      Rsel_d;
  logic [1:0]           Wsel_q,      Wsel_d;

  // flush beats stall; rst is applied in the sequential block above both.
  always_comb begin
    valid_d     = valid_q;
    aluresult_d = aluresult_q;
    storedata_d = storedata_q;
    pc4_d       = pc4_q;
    regd_d      = regd_q;
    Wbsel_d     = Wbsel_q;
    MemRw_d     = MemRw_q;
    RegWen_d    = RegWen_q;
    Rsel_d      = Rsel_q;
    Wsel_d      = Wsel_q;
    if (flush) begin
      valid_d     = 1'b0;
      aluresult_d = '0;
      storedata_d = '0;
      pc4_d       = '0;
      regd_d      = '0;
      Wbsel_d     = '0;
      MemRw_d     = 1'b0;
      RegWen_d    = 1'b0;
      Rsel_d      = '0;
      Wsel_d      = '0;
    end else if (en) begin
      valid_d     = valid_in;
      aluresult_d = aluresult_in;
      storedata_d = storedata_in;
      pc4_d       = pc4_in;
      regd_d      = regd_in;
      Wbsel_d     = Wbsel_in;
      // An invalid slot must never carry a store or register write.
      MemRw_d     = MemRw_in & valid_in;
      RegWen_d    = RegWen_in & valid_in;
      Rsel_d      = Rsel_in;
      Wsel_d      = Wsel_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      aluresult_q <= '0;
      storedata_q <= '0;
      pc4_q       <= '0;
      regd_q      <= '0;
      Wbsel_q     <= '0;
      MemRw_q     <= 1'b0;
      RegWen_q    <= 1'b0;
      Rsel_q      <= '0;
      Wsel_q      <= '0;
    end else begin
      valid_q     <= valid_d;
      aluresult_q <= aluresult_d;
      storedata_q <= storedata_d;
      pc4_q       <= pc4_d;
      regd_q      <= regd_d;
      Wbsel_q     <= Wbsel_d;
      MemRw_q     <= MemRw_d;
      RegWen_q    <= RegWen_d;
      Rsel_q      <= Rsel_d;
      Wsel_q      <= Wsel_d;
    end
  end

  logic writes_rd;

  always_comb begin
    writes_rd = valid_q & RegWen_q & (regd_q != '0);

    valid_out     = valid_q;
    aluresult_out = aluresult_q;
    storedata_out = storedata_q;
    pc4_out       = pc4_q;
    regd_out      = regd_q;
    Wbsel_out     = Wbsel_q;
    MemRw_out     = MemRw_q & valid_q;
    RegWen_out    = RegWen_q & valid_q;
    Rsel_out      = Rsel_q;
    Wsel_out      = Wsel_q;

    // Wbsel = 11 selects no source: it neither forwards nor flags a load.
    fwd_regd     = regd_q;
    fwd_valid    = writes_rd & ((Wbsel_q == WB_ALU) | (Wbsel_q == WB_PC4));
    load_pending = writes_rd & (Wbsel_q == WB_MEM);
    fwd_data     = '0;
    if (Wbsel_q == WB_ALU)      fwd_data = aluresult_q;
    else if (Wbsel_q == WB_PC4) fwd_data = pc4_q;
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst, en, flush, valid_in;
  logic [31:0] aluresult_in, storedata_in, pc4_in;
  logic [4:0]  regd_in;
  logic [1:0]  Wbsel_in, Wsel_in;
  logic        MemRw_in, RegWen_in;
  logic [2:0]  Rsel_in;
  logic        valid_out, MemRw_out, RegWen_out, fwd_valid, load_pending;
  logic [31:0] aluresult_out, storedata_out, pc4_out, fwd_data;
  logic [4:0]  regd_out, fwd_regd;
  logic [1:0]  Wbsel_out, Wsel_out;
  logic [2:0]  Rsel_out;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  ex_mem_stage #(.datawidth(32), .regindex(5)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .valid_in(valid_in),
    .aluresult_in(aluresult_in), .storedata_in(storedata_in), .pc4_in(pc4_in),
    .regd_in(regd_in), .Wbsel_in(Wbsel_in), .MemRw_in(MemRw_in),
    .RegWen_in(RegWen_in), .Rsel_in(Rsel_in), .Wsel_in(Wsel_in),
    .valid_out(valid_out), .aluresult_out(aluresult_out),
    .storedata_out(storedata_out), .pc4_out(pc4_out), .regd_out(regd_out),
    .Wbsel_out(Wbsel_out), .MemRw_out(MemRw_out), .RegWen_out(RegWen_out),
    .Rsel_out(Rsel_out), .Wsel_out(Wsel_out), .fwd_valid(fwd_valid),
    .fwd_regd(fwd_regd), .fwd_data(fwd_data), .load_pending(load_pending)
  );

  // Reference: contents of the stage as an instruction record.
  typedef struct {
    bit          valid;
    logic [31:0] alu, sd, pc4;
    logic [4:0]  rd;
    logic [1:0]  wb;
    bit          mw, rw;
    logic [2:0]  rs;
    logic [1:0]  ws;
    bit          known;  // control selects are well defined (valid or cleared)
  } slot_t;

  slot_t m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic slot_t empty_slot();
    slot_t s;
    s.valid = 0; s.alu = 0; s.sd = 0; s.pc4 = 0; s.rd = 0; s.wb = 0;
    s.mw = 0; s.rw = 0; s.rs = 0; s.ws = 0; s.known = 1;
    return s;
  endfunction

  task automatic model_edge();
    if (rst || flush) m = empty_slot();
    else if (en) begin
      m.valid = valid_in;  m.alu = aluresult_in; m.sd = storedata_in;
      m.pc4 = pc4_in;      m.rd = regd_in;       m.wb = Wbsel_in;
      m.mw = valid_in && MemRw_in;  m.rw = valid_in && RegWen_in;
      m.rs = Rsel_in;      m.ws = Wsel_in;       m.known = valid_in;
    end
  endtask

  task automatic check_all();
    bit wr;
    logic [31:0] fd;
    wr = m.valid && m.rw && (m.rd != 0);
    chk("valid_out", {31'd0, valid_out}, {31'd0, m.valid});
    chk("aluresult_out", aluresult_out, m.alu);
    chk("storedata_out", storedata_out, m.sd);
    chk("pc4_out", pc4_out, m.pc4);
    chk("regd_out", {27'd0, regd_out}, {27'd0, m.rd});
    chk("fwd_regd", {27'd0, fwd_regd}, {27'd0, m.rd});
    chk("MemRw_out", {31'd0, MemRw_out}, {31'd0, m.valid && m.mw});
    chk("RegWen_out", {31'd0, RegWen_out}, {31'd0, m.valid && m.rw});
    chk("fwd_valid", {31'd0, fwd_valid}, {31'd0, wr && (m.wb == 2'd1 || m.wb == 2'd2)});
    chk("load_pending", {31'd0, load_pending}, {31'd0, wr && m.wb == 2'd0});
    if (m.known) begin
      fd = (m.wb == 2'd1) ? m.alu : (m.wb == 2'd2) ? m.pc4 : 32'd0;
      chk("fwd_data", fwd_data, fd);
      chk("Wbsel_out", {30'd0, Wbsel_out}, {30'd0, m.wb});
      chk("Rsel_out", {29'd0, Rsel_out}, {29'd0, m.rs});
      chk("Wsel_out", {30'd0, Wsel_out}, {30'd0, m.ws});
    end
  endtask

  // Inputs are stable from #1 after the previous edge; outputs sampled #1 after.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic rand_fields();
    valid_in     = 1'($urandom_range(0, 3) != 0);
    aluresult_in = $urandom;
    storedata_in = $urandom;
    pc4_in       = $urandom;
    regd_in      = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
    Wbsel_in     = 2'($urandom_range(0, 3));
    MemRw_in     = 1'($urandom);
    RegWen_in    = 1'($urandom);
    Rsel_in      = 3'($urandom);
    Wsel_in      = 2'($urandom);
  endtask

  task automatic set_op(input bit v, input logic [31:0] alu, input logic [31:0] pc4,
                        input logic [4:0] rd, input logic [1:0] wb, input bit mw, input bit rw);
    valid_in = v; aluresult_in = alu; pc4_in = pc4; regd_in = rd;
    Wbsel_in = wb; MemRw_in = mw; RegWen_in = rw;
    storedata_in = 32'hCAFE_0000 | {27'd0, rd}; Rsel_in = 3'd2; Wsel_in = 2'd1;
  endtask

  initial begin
    m = empty_slot();
    // Reset with nonzero inputs and en high.
    rst = 1; en = 1; flush = 0;
    set_op(1, 32'hDEAD_BEEF, 32'h44, 5'd9, 2'b01, 1, 1);
    cycle(); cycle();
    rst = 0;

    // Capture an ALU result.
    set_op(1, 32'h0000_1000, 32'h10, 5'd5, 2'b01, 0, 1);
    cycle();
    chk("capture_fwd_data", fwd_data, 32'h0000_1000);
    chk("capture_fwd_valid", {31'd0, fwd_valid}, 32'd1);

    // Stall for 3 cycles while inputs change, then capture.
    en = 0;
    for (int i = 0; i < 3; i++) begin
      rand_fields();
      cycle();
    end
    en = 1;
    set_op(1, 32'h0000_2222, 32'h20, 5'd6, 2'b01, 0, 1);
    cycle();

    // Captured store, then flush while stalled.
    set_op(1, 32'h0000_3000, 32'h30, 5'd0, 2'b00, 1, 0);
    cycle();
    en = 0; flush = 1;
    cycle();
    chk("flush_valid", {31'd0, valid_out}, 32'd0);
    en = 1; flush = 0;

    // Load to x7, then load to x0.
    set_op(1, 32'h0000_4000, 32'h40, 5'd7, 2'b00, 0, 1);
    cycle();
    chk("load_pending_x7", {31'd0, load_pending}, 32'd1);
    set_op(1, 32'h0000_4004, 32'h44, 5'd0, 2'b00, 0, 1);
    cycle();

    // Invalid input with write controls set.
    set_op(0, 32'h0000_5000, 32'h50, 5'd8, 2'b01, 1, 1);
    cycle();

    // JAL-style writeback of PC+4.
    set_op(1, 32'h0000_6000, 32'h0000_0084, 5'd1, 2'b10, 0, 1);
    cycle();
    chk("jal_fwd_data", fwd_data, 32'h0000_0084);

    // Reserved writeback select.
    set_op(1, 32'h0000_7000, 32'h70, 5'd3, 2'b11, 0, 1);
    cycle();

    // Reset while stalled and flushing.
    set_op(1, 32'h0000_8000, 32'h80, 5'd4, 2'b01, 0, 1);
    cycle();
    rst = 1; en = 0; flush = 1;
    cycle();
    rst = 0; flush = 0; en = 1;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rand_fields();
      rst   = 1'($urandom_range(0, 29) == 0);
      flush = 1'($urandom_range(0, 9) == 0);
      en    = 1'($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
